// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single pipelined main memory between the I-cache
// fill FSM, the D-cache fill FSM and the D-cache write-through path.
// A grant covers one whole transaction: one block fill or one word write.
// Fill reads are issued back-to-back; returns are counted, not timed.
//
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN
//   defined   -> an I/D fill tie goes to the fill requester not served last
//   undefined -> fixed D-over-I priority
// The write-through path is always highest priority.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no transaction; arbitrate among pending requests
// S_WRITE | single-cycle word write to memory, w_ack pulses
// S_FILL  | block fill: issue WORDS_PER_BLOCK reads, route returns to owner

module mem_arbiter #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int MEM_LATENCY     = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic        i_data_valid,
    output logic        i_done,

    input  logic        d_req,
    input  logic [15:0] d_addr,
    output logic        d_grant,
    output logic        d_data_valid,
    output logic        d_done,

    input  logic        w_req,
    input  logic [15:0] w_addr,
    input  logic [15:0] w_data,
    output logic        w_ack,

    output logic [15:0] fill_data,
    output logic [15:0] fill_word_addr,

    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdata_valid
);

    // Counters need one extra bit so they can hold WORDS_PER_BLOCK itself.
    localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
    // Blocks are WORDS_PER_BLOCK 16-bit words of byte-addressed memory.
    localparam int                BASE_LSB  = $clog2(WORDS_PER_BLOCK) + 1;
    localparam logic [15:0]       BASE_MASK = 16'hFFFF << BASE_LSB;
    localparam logic [CW-1:0]     CNT_FULL  = CW'(WORDS_PER_BLOCK);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(WORDS_PER_BLOCK - 1);

    // MEM_LATENCY is documentation only: returns are counted, never timed.
    // An illegal parameter set elaborates this empty marker block.
    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0 ||
        MEM_LATENCY < 1) begin : g_bad_params
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    // Owner / last-fill encoding: 0 = I-cache, 1 = D-cache
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_issue_cnt;
    logic [CW-1:0]   r_ret_cnt;
    logic            r_owner;
    logic [15:0]     r_base;
    logic [15:0]     r_waddr;
    logic [15:0]     r_wdata;
    logic            w_pick_d;
    logic            w_issue_more;
    logic            w_fill_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic            r_last_fill;

    // Fill arbitration: on an I/D tie, the one not served last wins.
    always_comb begin
        w_pick_d = d_req && (!i_req || (r_last_fill == OWN_I));
    end
`else
    // Fill arbitration: fixed D-over-I priority.
    always_comb begin
        w_pick_d = d_req;
    end
`endif

    assign w_issue_more = (r_issue_cnt < CNT_FULL);
    assign w_fill_last  = mem_rdata_valid && (r_ret_cnt == CNT_LAST);
    assign fill_data    = mem_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transaction datapath: latched request, fill base/owner, issue and return counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_owner     <= OWN_I;
            r_base      <= '0;
            r_waddr     <= '0;
            r_wdata     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_fill <= OWN_I;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_waddr <= w_addr;
                        r_wdata <= w_data;
                    end else if (d_req || i_req) begin
                        r_owner     <= w_pick_d ? OWN_D : OWN_I;
                        r_base      <= (w_pick_d ? d_addr : i_addr) & BASE_MASK;
                        r_issue_cnt <= '0;
                        r_ret_cnt   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        r_last_fill <= w_pick_d ? OWN_D : OWN_I;
`endif
                    end
                end
                S_FILL: begin
                    if (w_issue_more) begin
                        r_issue_cnt <= r_issue_cnt + CW'(1);
                    end
                    if (mem_rdata_valid) begin
                        r_ret_cnt <= r_ret_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode; every output idles at 0.
    always_comb begin
        w_next_state   = r_state;
        i_grant        = 1'b0;
        d_grant        = 1'b0;
        i_data_valid   = 1'b0;
        d_data_valid   = 1'b0;
        i_done         = 1'b0;
        d_done         = 1'b0;
        w_ack          = 1'b0;
        mem_en         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        fill_word_addr = '0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next_state = S_WRITE;
                end else if (d_req || i_req) begin
                    w_next_state = S_FILL;
                end
            end
            S_WRITE: begin
                mem_en       = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = r_waddr;
                mem_wdata    = r_wdata;
                w_ack        = 1'b1;
                w_next_state = S_IDLE;
            end
            S_FILL: begin
                i_grant = (r_owner == OWN_I);
                d_grant = (r_owner == OWN_D);
                if (w_issue_more) begin
                    mem_en   = 1'b1;
                    mem_addr = r_base + 16'({r_issue_cnt, 1'b0});
                end
                if (mem_rdata_valid) begin
                    i_data_valid   = (r_owner == OWN_I);
                    d_data_valid   = (r_owner == OWN_D);
                    fill_word_addr = r_base + 16'({r_ret_cnt, 1'b0});
                end
                if (w_fill_last) begin
                    i_done       = (r_owner == OWN_I);
                    d_done       = (r_owner == OWN_D);
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (WORDS_PER_BLOCK=8).
// Stimulus pushes expected memory accesses and expected returned words;
// a negedge monitor pops and compares whenever the DUT presents them.
// Memory model: fixed 4-cycle read latency, data = byte-swapped addr ^ 5A5A.

module tb_mem_arbiter;

    localparam int WPB = 8;
    localparam logic [1:0] WHO_I = 2'd0;
    localparam logic [1:0] WHO_D = 2'd1;
    localparam logic [1:0] WHO_W = 2'd2;

    logic        clk;
    logic        rst;
    logic        i_req, d_req, w_req;
    logic [15:0] i_addr, d_addr, w_addr, w_data;
    logic        i_grant, i_data_valid, i_done;
    logic        d_grant, d_data_valid, d_done;
    logic        w_ack;
    logic [15:0] fill_data, fill_word_addr;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rdata_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  who;
    } mem_exp_t;

    typedef struct packed {
        logic [1:0]  who;
        logic [15:0] addr;
        logic [15:0] data;
        logic        done;
    } ret_exp_t;

    mem_exp_t q_mem[$];
    ret_exp_t q_ret[$];

    mem_arbiter #(.WORDS_PER_BLOCK(WPB), .MEM_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
        .i_data_valid(i_data_valid), .i_done(i_done),
        .d_req(d_req), .d_addr(d_addr), .d_grant(d_grant),
        .d_data_valid(d_data_valid), .d_done(d_done),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
        .fill_data(fill_data), .fill_word_addr(fill_word_addr),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    // Pipelined read-only memory model, 4 cycles from mem_en to valid.
    logic [3:0]  pv = '0;
    logic [15:0] pa0 = '0, pa1 = '0, pa2 = '0, pa3 = '0;
    always @(posedge clk) begin
        pv  <= {pv[2:0], mem_en & ~mem_wr};
        pa0 <= mem_addr;
        pa1 <= pa0;
        pa2 <= pa1;
        pa3 <= pa2;
    end
    assign mem_rdata_valid = pv[3];
    assign mem_rdata       = mem_model(pa3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] who_grants(input logic [1:0] who);
        case (who)
            WHO_I:   return 3'b100;
            WHO_D:   return 3'b010;
            default: return 3'b001;
        endcase
    endfunction

    task automatic push_write(input logic [15:0] a, input logic [15:0] d);
        q_mem.push_back('{wr: 1'b1, addr: a, wdata: d, who: WHO_W});
    endtask

    task automatic push_fill(input logic [1:0] who, input logic [15:0] base);
        for (int k = 0; k < WPB; k++) begin
            q_mem.push_back('{wr: 1'b0, addr: base + 16'(2 * k), wdata: 16'h0, who: who});
            q_ret.push_back('{who: who, addr: base + 16'(2 * k),
                              data: mem_model(base + 16'(2 * k)), done: (k == WPB - 1)});
        end
    endtask

    // Monitor: compares each memory access and each returned word with the scoreboard.
    always @(negedge clk) begin
        mem_exp_t me;
        ret_exp_t re;
        check("fill_data_passthru", 32'(fill_data), 32'(mem_rdata));
        check("grant_overlap", 32'(i_grant & d_grant), 32'd0);
        if (mem_en) begin
            if (q_mem.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_mem_access: got addr %h wr %b, expected none (t=%0t)",
                         mem_addr, mem_wr, $time);
            end else begin
                me = q_mem.pop_front();
                check("mem_wr", 32'(mem_wr), 32'(me.wr));
                check("mem_addr", 32'(mem_addr), 32'(me.addr));
                if (me.wr) check("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
                check("owner_grant_ack", 32'({i_grant, d_grant, w_ack}), 32'(who_grants(me.who)));
            end
        end else begin
            check("w_ack_without_access", 32'(w_ack), 32'd0);
        end
        if (i_data_valid || d_data_valid) begin
            if (q_ret.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_data_valid: got i/d valid %b%b, expected none (t=%0t)",
                         i_data_valid, d_data_valid, $time);
            end else begin
                re = q_ret.pop_front();
                check("data_valid_owner", 32'({i_data_valid, d_data_valid}),
                      32'((re.who == WHO_I) ? 2'b10 : 2'b01));
                check("fill_word_addr", 32'(fill_word_addr), 32'(re.addr));
                check("fill_data", 32'(fill_data), 32'(re.data));
                check("done_pulse", 32'({i_done, d_done}),
                      32'(re.done ? ((re.who == WHO_I) ? 2'b10 : 2'b01) : 2'b00));
            end
        end else begin
            check("done_without_valid", 32'({i_done, d_done}), 32'd0);
            check("fill_word_addr_idle", 32'(fill_word_addr), 32'd0);
        end
    end

    // which: 0 i_done, 1 d_done, 2 w_ack, 3 either done. Returns #1 after the next posedge.
    task automatic wait_pulse(input int which, input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            case (which)
                0:       seen = i_done;
                1:       seen = d_done;
                2:       seen = w_ack;
                default: seen = i_done | d_done;
            endcase
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_%s: got no pulse, expected one within 200 cycles", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctrl"}, 32'({i_grant, d_grant, i_data_valid, d_data_valid,
                                    i_done, d_done, w_ack, mem_en, mem_wr}), 32'd0);
        check({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({name, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({name, "_fill_word_addr"}, 32'(fill_word_addr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of test, expected one before 200us");
        $fatal(1, "global timeout");
    end

    initial begin
        int cnt;
        rst = 1'b1;
        i_req = 1'b0; d_req = 1'b0; w_req = 1'b0;
        i_addr = '0; d_addr = '0; w_addr = '0; w_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_state");

        // I-fill alone
        @(posedge clk); #1;
        i_addr = 16'h1236;
        push_fill(WHO_I, 16'h1230);
        i_req = 1'b1;
        wait_pulse(0, "i_fill_alone");
        i_req = 1'b0;

        // Single write, then IDLE
        push_write(16'h00A4, 16'hBEEF);
        w_addr = 16'h00A4; w_data = 16'hBEEF; w_req = 1'b1;
        wait_pulse(2, "write_ack");
        w_req = 1'b0;
        @(negedge clk);
        check("idle_after_write", 32'({mem_en, w_ack, i_grant, d_grant}), 32'd0);

        // Simultaneous requests: write, then D fill, then I fill
        @(posedge clk); #1;
        push_write(16'h0010, 16'h1234);
        push_fill(WHO_D, 16'h5550);
        push_fill(WHO_I, 16'h3330);
        w_addr = 16'h0010; w_data = 16'h1234; d_addr = 16'h555F; i_addr = 16'h333A;
        w_req = 1'b1; d_req = 1'b1; i_req = 1'b1;
        wait_pulse(2, "simul_write");
        w_req = 1'b0;
        wait_pulse(1, "simul_d_fill");
        d_req = 1'b0;
        wait_pulse(0, "simul_i_fill");
        i_req = 1'b0;

        // D and I held across three fills
        d_addr = 16'h4C5B; i_addr = 16'h0A0F;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_fill(WHO_D, 16'h4C50);
        push_fill(WHO_I, 16'h0A00);
        push_fill(WHO_D, 16'h4C50);
`else
        push_fill(WHO_D, 16'h4C50);
        push_fill(WHO_D, 16'h4C50);
        push_fill(WHO_D, 16'h4C50);
`endif
        d_req = 1'b1; i_req = 1'b1;
        for (int f = 0; f < 3; f++) wait_pulse(3, "held_fill");
        d_req = 1'b0; i_req = 1'b0;

        // Reset after the 3rd return of a D fill
        d_addr = 16'h7F33;
        push_fill(WHO_D, 16'h7F30);
        d_req = 1'b1;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 3; k++) begin
            @(negedge clk);
            if (d_data_valid) cnt++;
        end
        check("third_return_seen", 32'(cnt), 32'd3);
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        // Reset landed after issue 8 and return 4 of the aborted fill.
        check("abort_mem_left", 32'(q_mem.size()), 32'd0);
        check("abort_ret_left", 32'(q_ret.size()), 32'd4);
        q_ret.delete();
        q_mem.delete();
        @(negedge clk);
        check_all_zero("after_abort");
        // Remaining returns of the aborted fill arrive in IDLE and must not be forwarded.
        repeat (8) @(posedge clk);
        #1;

        // New I fill after reset
        i_addr = 16'h2468;
        push_fill(WHO_I, 16'h2460);
        i_req = 1'b1;
        wait_pulse(0, "i_fill_after_reset");
        i_req = 1'b0;

        repeat (10) @(posedge clk);
        check("q_mem_drained", 32'(q_mem.size()), 32'd0);
        check("q_ret_drained", 32'(q_ret.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences the single shared main memory between three requesters: the I-cache fill FSM, the D-cache fill FSM, and the D-cache write-through path.
- Grants the memory for a whole transaction: one block fill or one word write.
- For a fill, issues every word read of the block back-to-back on the pipelined memory.
- Routes the returning data and its word address to the owning fill FSM, and signals completion.
- Sits between the two cache fill FSMs and the memory model.

Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block. Power of two, at least 2.
- MEM_LATENCY, 4: cycles from mem_en to mem_rdata_valid. Informational only; the block counts returns and does not time them.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- i_req  in  1  I-cache fill request; held until i_done
- i_addr  in  16  I-cache miss address
- i_grant  out  1  high while the I-cache fill owns memory
- i_data_valid  out  1  returned word belongs to the I-cache
- i_done  out  1  one-cycle pulse on the last I-cache word
- d_req  in  1  D-cache fill request; held until d_done
- d_addr  in  16  D-cache miss address
- d_grant  out  1  high while the D-cache fill owns memory
- d_data_valid  out  1  returned word belongs to the D-cache
- d_done  out  1  one-cycle pulse on the last D-cache word
- w_req  in  1  write-through request; held until w_ack
- w_addr  in  16  write address
- w_data  in  16  write data
- w_ack  out  1  one-cycle pulse when the write is issued
- fill_data  out  16  mem_rdata passed through
- fill_word_addr  out  16  address of the word currently returning
- mem_en  out  1  memory enable
- mem_wr  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data
- mem_rdata_valid  in  1  memory read data valid

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, WRITE, FILL.
- Reset (rst high at an edge):
  - state goes to IDLE; issue_cnt and ret_cnt clear to 0; owner and last-fill are set to I.
  - All outputs go to 0: grants, data_valids, done pulses, w_ack, mem_en, mem_wr, mem_addr, mem_wdata.
  - Reset mid-FILL or mid-WRITE aborts the transaction; no done pulse or ack is produced.
- IDLE, default priority is w_req > d_req > i_req:
  - w_req: go to WRITE and latch w_addr and w_data.
  - Otherwise d_req or i_req: go to FILL. Latch base = addr with its low log2(WORDS_PER_BLOCK)+1 bits cleared, and latch the owner.
  - No request: stay in IDLE. mem_en is 0.
- WRITE, lasts exactly one cycle:
  - mem_en=1, mem_wr=1, mem_addr and mem_wdata come from the latched values, w_ack=1.
  - Next state is IDLE.
  - Latency: w_req sampled at edge N, so mem_en and w_ack are high in cycle N+1.
- FILL:
  - The owner's grant is high in every FILL cycle.
  - While issue_cnt < WORDS_PER_BLOCK: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt, and issue_cnt increments.
  - After issue_cnt reaches WORDS_PER_BLOCK: mem_en=0.
  - When mem_rdata_valid=1:
    - the owner's data_valid is 1 (the other requester's stays 0);
    - fill_word_addr = base + 2*ret_cnt;
    - ret_cnt increments.
  - The valid that makes ret_cnt reach WORDS_PER_BLOCK also pulses the owner's done in that same cycle; the next state is IDLE.
  - All adds are 16-bit modulo. A block never crosses an alignment boundary, so no wrap occurs inside a block.
- Boundary and corner cases:
  - Returns arriving while issuing still count; issue and return may overlap in the same cycle.
  - mem_rdata_valid outside FILL is ignored and not forwarded.
  - Requests arriving during WRITE or FILL wait in their req line. Arbitration happens only in IDLE.
  - Dropping a req mid-transaction is ignored; the transaction completes.
  - A requester must deassert req in the cycle after its done or ack. A req still high in that IDLE cycle is treated as a new request.
  - fill_data always equals mem_rdata.
  - fill_word_addr is 0 when no valid word is returning.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - When d_req and i_req are both high in IDLE with no w_req, the grant goes to the fill requester not served last (tracked by last-fill, reset to I, so D wins the first tie).
  - last-fill updates on each fill grant.
  - w_req stays highest priority.
- Undefined: fixed D-over-I priority; last-fill is not implemented.

Test Plan:
- I-fill alone: i_req=1 with i_addr=0x1236, memory latency 4:
  - mem_addr = 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles;
  - 8 i_data_valid with fill_word_addr 0x1230…0x123E;
  - i_done coincides with the 8th valid; d_data_valid stays 0.
- Write: w_req=1, w_addr=0x00A4, w_data=0xBEEF:
  - the next cycle shows mem_en=1, mem_wr=1, mem_addr=0x00A4, mem_wdata=0xBEEF, w_ack=1;
  - the state is IDLE the cycle after.
- Simultaneous w_req, d_req, i_req:
  - write first, then D fill (base from d_addr), then I fill;
  - no memory access overlaps another transaction.
- Without MEM_ARB_ROUND_ROBIN_EN: d_req and i_req held high across three fills → D served every time.
- With MEM_ARB_ROUND_ROBIN_EN, same stimulus → grants D, I, D.
- rst asserted after the 3rd return of a D fill:
  - all outputs are 0 the next cycle; no d_done;
  - stray mem_rdata_valid in IDLE produces no data_valid;
  - a new i_req is then served normally.
